// File: rtl/seq_operand_unpacker.sv
// Unpacks a 32-bit stream of densely packed signed operands into one MAC job
// (K row elements, K column elements, accumulator seed) behind a valid/ready output.
module seq_operand_unpacker #(
    parameter int K         = 2,
    parameter int MAX_WIDTH = 16,
    parameter int P         = 2,
    parameter int BSW       = $clog2(MAX_WIDTH / P) + 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [31:0]                  in_data,
    input  logic [BSW-1:0]               in_bitSizeA,
    input  logic [BSW-1:0]               in_bitSizeB,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [K-1:0][MAX_WIDTH-1:0]  row,
    output logic [K-1:0][MAX_WIDTH-1:0]  column,
    output logic [31:0]                  C_out,
    output logic [BSW-1:0]               bitSizeA_o,
    output logic [BSW-1:0]               bitSizeB_o,
    output logic                         valid_out,
    input  logic                         ready_out
);

    localparam int MAXG = MAX_WIDTH / P;
    localparam int IW   = $clog2(K) + 1;

    typedef enum logic [1:0] {S_ROW, S_COL, S_CWORD} state_t;

    state_t                       state;
    logic [IW-1:0]                word_idx;
    logic [K-1:0][MAX_WIDTH-1:0]  row_stg;
    logic [K-1:0][MAX_WIDTH-1:0]  col_stg;
    logic [BSW-1:0]               bsa_stg;
    logic [BSW-1:0]               bsb_stg;

    logic                         first_word;
    logic [BSW-1:0]               bsa_cur;
    int                           w_a, w_b, epw_a, epw_b, nw_a, nw_b, base;
    logic                         accept;

    function automatic logic [BSW-1:0] clamp_bs(input logic [BSW-1:0] bs);
        if (bs == '0 || int'(bs) > MAXG) return BSW'(MAXG);
        return bs;
    endfunction

    function automatic int width_of(input logic [BSW-1:0] bs);
        return int'(clamp_bs(bs)) * P;
    endfunction

    // Pull element 'slot' of width w out of a word and sign-extend it to MAX_WIDTH.
    function automatic logic [MAX_WIDTH-1:0] extract(input logic [31:0] word,
                                                     input int slot, input int w);
        logic [31:0]          sh;
        logic [MAX_WIDTH-1:0] raw;
        int                   pad;
        sh  = word >> (slot * w);
        raw = sh[MAX_WIDTH-1:0];
        pad = MAX_WIDTH - w;
        raw = raw << pad;
        return $signed(raw) >>> pad;
    endfunction

    // The first word of a job uses the live size inputs; later words use the latched sizes.
    always_comb begin
        first_word = (state == S_ROW) && (word_idx == '0);
        bsa_cur    = first_word ? clamp_bs(in_bitSizeA) : bsa_stg;
        w_a        = width_of(bsa_cur);
        w_b        = width_of(bsb_stg);
        epw_a      = 32 / w_a;
        epw_b      = 32 / w_b;
        nw_a       = (K + epw_a - 1) / epw_a;
        nw_b       = (K + epw_b - 1) / epw_b;
        base       = int'(word_idx) * ((state == S_COL) ? epw_b : epw_a);
    end

    assign in_ready = (state != S_CWORD) || !valid_out || ready_out;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_ROW;
            word_idx   <= '0;
            row_stg    <= '0;
            col_stg    <= '0;
            bsa_stg    <= '0;
            bsb_stg    <= '0;
            row        <= '0;
            column     <= '0;
            C_out      <= '0;
            bitSizeA_o <= '0;
            bitSizeB_o <= '0;
            valid_out  <= 1'b0;
        end else begin
            // A load in the CWORD branch below overrides this clear on a simultaneous handshake.
            if (valid_out && ready_out) valid_out <= 1'b0;
            if (accept) begin
                unique case (state)
                    S_ROW: begin
                        if (first_word) begin
                            bsa_stg <= bsa_cur;
                            bsb_stg <= clamp_bs(in_bitSizeB);
                        end
                        for (int e = 0; e < K; e++)
                            if (e >= base && e < base + epw_a)
                                row_stg[e] <= extract(in_data, e - base, w_a);
                        if (int'(word_idx) + 1 >= nw_a) begin
                            state    <= S_COL;
                            word_idx <= '0;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                    S_COL: begin
                        for (int e = 0; e < K; e++)
                            if (e >= base && e < base + epw_b)
                                col_stg[e] <= extract(in_data, e - base, w_b);
                        if (int'(word_idx) + 1 >= nw_b) begin
                            state    <= S_CWORD;
                            word_idx <= '0;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                    S_CWORD: begin
                        row        <= row_stg;
                        column     <= col_stg;
                        C_out      <= in_data;
                        bitSizeA_o <= bsa_stg;
                        bitSizeB_o <= bsb_stg;
                        valid_out  <= 1'b1;
                        state      <= S_ROW;
                        word_idx   <= '0;
                    end
                    default: state <= S_ROW;
                endcase
            end
        end
    end

endmodule

// File: doc/seq_operand_unpacker.md
# seq_operand_unpacker

- Sits directly upstream of the sequential multiply-accumulate stage and supplies its operand bundle.
- Consumes a 32-bit word stream of densely packed, variable-precision signed operands.
- Assembles one job: K row elements, K column elements and a 32-bit accumulator seed. Sign-extends every element to MAX_WIDTH.
- Presents the job with a valid/ready handshake. One staging buffer and one output register let the next job load while the current one waits.

## Interface

Parameters:
- K, 2, elements per row/column vector
- MAX_WIDTH, 16, output element width in bits
- P, 2, precision granule in bits; element width W = bitSize·P
- BSW, $clog2(MAX_WIDTH/P)+2, bitSize port width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_data  in  32  packed operand word
- in_bitSizeA  in  BSW  row precision in granules; sampled on first word of a job
- in_bitSizeB  in  BSW  column precision in granules; sampled on first word of a job
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid & in_ready
- row  out  K×MAX_WIDTH signed  row operands
- column  out  K×MAX_WIDTH signed  column operands
- C_out  out  32  accumulator seed
- bitSizeA_o  out  BSW  job row precision
- bitSizeB_o  out  BSW  job column precision
- valid_out  out  1  bundle valid
- ready_out  in  1  downstream ready

## Operation

Element packing:
- Elements per word EPW = floor(32/W): W=16→2, 8→4, 4→8, 2→16; odd sizes likewise, e.g. W=6→5.
- Element i of a word occupies bits [i·W+W-1 : i·W], LSB-first. Elements never straddle words; the unused upper bits are ignored.
- Words per vector NW = ceil(K/EPW). In the last word, slots ≥ the remaining count are ignored.
- bitSize 0 or > MAX_WIDTH/P is clamped to MAX_WIDTH/P.

Sign extension:
- Each element is sign-extended from W bits to MAX_WIDTH.
- With W = MAX_WIDTH the element passes unchanged.

Job word order: NW_A row words, then NW_B column words, then 1 C word (copied verbatim).

FSM:
- ROW: counts row words. Entered at reset and after each C word.
  - The first accepted word latches the clamped bitSizeA/B into staging and computes EPW_A/EPW_B and NW_A/NW_B.
  - After NW_A words → COL.
- COL: counts column words using the latched bitSizeB; after NW_B words → CWORD.
- CWORD: the accepted word becomes C.
  - Staging (rows, columns, C, sizes) is copied into the output register and valid_out is set.
  - The FSM returns to ROW.

in_ready:
- High in ROW and COL.
- In CWORD: in_ready = ~valid_out | ready_out.

Output register:
- Holds its contents while valid_out & ~ready_out.
- valid_out clears on a handshake with no simultaneous load.
- A load in the same cycle as a handshake keeps valid_out = 1 with the new contents.

Staging:
- Element write index = word_idx·EPW + slot.
- Index counters reset to 0 on each phase entry.

## Timing

- Reset values:
  - in_ready = 1
  - valid_out = 0
  - row, column, C_out = 0
  - bitSizeA_o, bitSizeB_o = 0
  - FSM = ROW, counters = 0
- Throughput: one word per cycle. A job takes NW_A + NW_B + 1 accepted words.
- Latency: valid_out rises the cycle after the C word is accepted.
- Back-to-back jobs: a new job's first row word may be accepted the cycle after the previous C word, even while valid_out is held.
- Simultaneous events: C-word acceptance coinciding with an output handshake loads the new bundle without a bubble.
- Back-pressure:
  - in_ready depends combinationally on ready_out only in CWORD.
  - No other in→out combinational path exists.
- Reset mid-job discards staging. Any pending bundle is lost and valid_out drops immediately.
- in_bitSizeA/B are ignored on every word except the first of a job.

## Test plan

Configuration: K=2, MAX_WIDTH=16, P=2 unless noted.

- bitSizeA=4, bitSizeB=8; words 0x0000807F, 0x80001234, 0x00000005 → one cycle later:
  - row = {0x007F, 0xFF80}, column = {0x1234, 0x8000}
  - C_out = 0x00000005, bitSizeA_o = 4, bitSizeB_o = 8
- bitSizeA=bitSizeB=1; words 0x0000000E, 0x00000001, 0xFFFFFFFF →
  - row = {0xFFFE, 0xFFFF}, column = {0x0001, 0x0000}
  - C_out = 0xFFFFFFFF
- K=4 variant, bitSizeA=8: row words 0x00020001, 0xFFFF0003 precede column words → row = {1, 2, 3, 0xFFFF}. Confirm the word count: NW_A = 2.
- Hold ready_out=0 after job 1:
  - job 2's row and column words are accepted; in_ready drops in CWORD.
  - Raising ready_out gives a job-1 handshake, then job-2 valid the next cycle. Outputs stay stable throughout the stall.
- Drop rst_ni during job 2's COL phase:
  - valid_out=0 and in_ready=1 immediately.
  - The next stream word is treated as a job's first row word, with sizes re-latched.
- bitSizeA=0 and bitSizeB=9 → both clamp to 8 and behave as 16-bit elements; bitSizeA_o = bitSizeB_o = 8.
